// File: rtl/spmv_row_mac_if.sv
// Handshake and data bundle between the SRAM0 reader / result sink and spmv_row_mac.
// master drives the row, beat and result-ready signals; slave is the MAC stage.
interface spmv_row_mac_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned ACC_W   = 40
);
    localparam int unsigned NnzW = $clog2(VEC_LEN + 1);
    localparam int unsigned ColW = $clog2(VEC_LEN);

    logic                        i_start;
    logic [NnzW-1:0]             i_nnz;
    logic [VEC_LEN*DATA_W-1:0]   i_in_vector;
    logic                        i_val_valid;
    logic [DATA_W-1:0]           i_mat_val;
    logic [ColW-1:0]             i_col_idx;
    logic                        o_val_ready;
    logic [ACC_W-1:0]            o_result;
    logic                        o_result_valid;
    logic                        i_result_ready;
    logic                        o_busy;
    logic [1:0]                  o_state;

    modport master (
        output i_start,
        output i_nnz,
        output i_in_vector,
        output i_val_valid,
        output i_mat_val,
        output i_col_idx,
        output i_result_ready,
        input  o_val_ready,
        input  o_result,
        input  o_result_valid,
        input  o_busy,
        input  o_state
    );

    modport slave (
        input  i_start,
        input  i_nnz,
        input  i_in_vector,
        input  i_val_valid,
        input  i_mat_val,
        input  i_col_idx,
        input  i_result_ready,
        output o_val_ready,
        output o_result,
        output o_result_valid,
        output o_busy,
        output o_state
    );
endinterface

// File: rtl/spmv_row_mac.sv
// SpMV row multiply-accumulate: snapshots the input vector at row start, sums value*vec[col]
// over the row's non-zeros and hands off the sum. Define SPMV_MAC_SAT_EN for a 32-bit clamp.
module spmv_row_mac #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned ACC_W   = 40
) (
    input logic           i_clk,
    input logic           i_rst,
    spmv_row_mac_if.slave bus
);
    localparam int unsigned NnzW  = $clog2(VEC_LEN + 1);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam int unsigned SatW  = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAccum = 2'b01,
        StOut   = 2'b10
    } state_e;

    state_e                    state_q, state_d;
    logic [VEC_LEN*DATA_W-1:0] vec_snap_q, vec_snap_d;
    logic [NnzW-1:0]           nnz_q, nnz_d;
    logic [NnzW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [ACC_W-1:0]          acc_q, acc_d;

    logic [NnzW-1:0]           nnz_eff;
    logic [DATA_W-1:0]         vec_elem [VEC_LEN];
    logic signed [ProdW-1:0]   prod;
    logic [ACC_W-1:0]          prod_ext;
    logic                      beat_accept;
    logic                      last_beat;
    logic [ACC_W-1:0]          result;

    // Counts above the vector length cannot address distinct columns; clamp them.
    assign nnz_eff = (bus.i_nnz > NnzW'(VEC_LEN)) ? NnzW'(VEC_LEN) : bus.i_nnz;

    for (genvar k = 0; k < VEC_LEN; k++) begin : g_elem
        assign vec_elem[k] = vec_snap_q[k*DATA_W +: DATA_W];
    end

    assign prod        = $signed(bus.i_mat_val) * $signed(vec_elem[bus.i_col_idx]);
    assign prod_ext    = {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};
    assign beat_accept = (state_q == StAccum) && bus.i_val_valid;
    assign last_beat   = (beat_cnt_q == nnz_q - NnzW'(1));

    always_comb begin
        state_d    = state_q;
        vec_snap_d = vec_snap_q;
        nnz_d      = nnz_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    vec_snap_d = bus.i_in_vector;
                    nnz_d      = nnz_eff;
                    beat_cnt_d = '0;
                    acc_d      = '0;
                    state_d    = (nnz_eff == '0) ? StOut : StAccum;
                end
            end
            StAccum: begin
                if (beat_accept) begin
                    acc_d      = acc_q + prod_ext;
                    beat_cnt_d = beat_cnt_q + NnzW'(1);
                    if (last_beat) begin
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (bus.i_result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            vec_snap_q <= '0;
            nnz_q      <= '0;
            beat_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_snap_q <= vec_snap_d;
            nnz_q      <= nnz_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
        end
    end

`ifdef SPMV_MAC_SAT_EN
    logic acc_in_range;

    // In range when every bit from the 32-bit sign position upward agrees.
    assign acc_in_range = (&acc_q[ACC_W-1:SatW-1]) | ~(|acc_q[ACC_W-1:SatW-1]);

    always_comb begin
        result = acc_q;
        if (!acc_in_range) begin
            if (acc_q[ACC_W-1]) begin
                result = {{(ACC_W - SatW + 1){1'b1}}, {(SatW - 1){1'b0}}};
            end else begin
                result = {{(ACC_W - SatW + 1){1'b0}}, {(SatW - 1){1'b1}}};
            end
        end
    end
`else
    assign result = acc_q;
`endif

    // All outputs decode registered state only, so no input reaches them combinationally.
    assign bus.o_val_ready    = (state_q == StAccum);
    assign bus.o_result_valid = (state_q == StOut);
    assign bus.o_result       = result;
    assign bus.o_busy         = (state_q != StIdle);
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_spmv_row_mac.sv
// Randomized self-checking bench for spmv_row_mac against a plain-arithmetic dot-product model.
// Honours SPMV_MAC_SAT_EN the same way as the design.
module tb_spmv_row_mac;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned VEC_LEN = 16;
    localparam int unsigned ACC_W   = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spmv_row_mac_if #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) bus_if ();

    spmv_row_mac #(.DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .ACC_W(ACC_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    logic [255:0] vec_g;
    int           val_q[$];
    int           col_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_result();
        longint      sum = 0;
        logic [63:0] s;
        for (int b = 0; b < val_q.size(); b++) begin
            int      c = col_q[b];
            shortint e = shortint'(vec_g[16*c +: 16]);
            sum += longint'(val_q[b]) * longint'(e);
        end
`ifdef SPMV_MAC_SAT_EN
        if (sum > 64'sd2147483647) sum = 64'sd2147483647;
        if (sum < -64'sd2147483648) sum = -64'sd2147483648;
`endif
        s = sum;
        return {24'b0, s[39:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec_elem(input int k, input int v);
        logic [31:0] w = v;
        vec_g[16*k +: 16] = w[15:0];
    endtask

    // Drives one full row from vec_g/val_q/col_q and checks timing, value and handoff.
    task automatic run_row(input int nnz, input int bubbles, input int hold, input bit poke,
                           output logic [39:0] res);
        int          eff = (nnz > 16) ? 16 : nnz;
        logic [63:0] exp = model_result();
        logic [4:0]  nnz5;
        nnz5 = 5'(nnz);
        bus_if.i_start        = 1'b1;
        bus_if.i_nnz          = nnz5;
        bus_if.i_in_vector    = vec_g;
        bus_if.i_val_valid    = 1'b0;
        bus_if.i_result_ready = 1'b0;
        tick();
        bus_if.i_start     = 1'b0;
        bus_if.i_in_vector = {8{$urandom()}};
        if (eff == 0) begin
            check_eq("empty_valid_edge1", 64'(bus_if.o_result_valid), 64'd1);
            check_eq("empty_val_ready", 64'(bus_if.o_val_ready), 64'd0);
        end else begin
            check_eq("accum_state", 64'(bus_if.o_state), 64'd1);
            check_eq("accum_val_ready", 64'(bus_if.o_val_ready), 64'd1);
            for (int b = 0; b < eff; b++) begin
                int v = val_q[b];
                int c = col_q[b];
                int nb = (bubbles > 0) ? int'($urandom_range(0, bubbles)) : 0;
                for (int g = 0; g < nb; g++) begin
                    bus_if.i_val_valid = 1'b0;
                    bus_if.i_mat_val   = 16'($urandom());
                    bus_if.i_col_idx   = 4'($urandom());
                    tick();
                    check_eq("bubble_no_result", 64'(bus_if.o_result_valid), 64'd0);
                end
                bus_if.i_val_valid = 1'b1;
                bus_if.i_mat_val   = v[15:0];
                bus_if.i_col_idx   = c[3:0];
                tick();
                if (b < eff - 1) check_eq("no_early_result", 64'(bus_if.o_result_valid), 64'd0);
            end
            bus_if.i_val_valid = 1'b0;
            check_eq("valid_after_last", 64'(bus_if.o_result_valid), 64'd1);
        end
        check_eq("result_value", 64'(bus_if.o_result), exp);
        check_eq("out_state", 64'(bus_if.o_state), 64'd2);
        check_eq("out_busy", 64'(bus_if.o_busy), 64'd1);
        res = bus_if.o_result;
        for (int h = 0; h < hold; h++) begin
            bus_if.i_val_valid = 1'b1;
            bus_if.i_mat_val   = 16'($urandom());
            bus_if.i_col_idx   = 4'($urandom());
            if (poke) begin
                bus_if.i_start     = 1'b1;
                bus_if.i_in_vector = {8{$urandom()}};
            end
            tick();
            check_eq("hold_stable", 64'(bus_if.o_result), exp);
            check_eq("hold_valid", 64'(bus_if.o_result_valid), 64'd1);
        end
        bus_if.i_val_valid    = 1'b0;
        bus_if.i_result_ready = 1'b1;
        bus_if.i_start        = poke;
        tick();
        bus_if.i_result_ready = 1'b0;
        bus_if.i_start        = 1'b0;
        check_eq("handoff_idle", 64'(bus_if.o_state), 64'd0);
        check_eq("handoff_valid_low", 64'(bus_if.o_result_valid), 64'd0);
        check_eq("handoff_busy_low", 64'(bus_if.o_busy), 64'd0);
    endtask

    task automatic load_basic();
        vec_g = '0;
        for (int k = 0; k < 16; k++) set_vec_elem(k, k + 1);
        val_q = '{2, -1, 4};
        col_q = '{0, 5, 15};
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_val_ready"}, 64'(bus_if.o_val_ready), 64'd0);
        check_eq({tag, "_result"}, 64'(bus_if.o_result), 64'd0);
        check_eq({tag, "_result_valid"}, 64'(bus_if.o_result_valid), 64'd0);
        check_eq({tag, "_busy"}, 64'(bus_if.o_busy), 64'd0);
        check_eq({tag, "_state"}, 64'(bus_if.o_state), 64'd0);
    endtask

    initial begin
        logic [39:0] res;
        bus_if.i_start        = 1'b0;
        bus_if.i_nnz          = '0;
        bus_if.i_in_vector    = '0;
        bus_if.i_val_valid    = 1'b0;
        bus_if.i_mat_val      = '0;
        bus_if.i_col_idx      = '0;
        bus_if.i_result_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        load_basic();
        run_row(3, 0, 0, 1'b0, res);
        check_eq("basic_60", 64'(res), 64'd60);

        val_q = {};
        col_q = {};
        run_row(0, 0, 2, 1'b0, res);
        check_eq("empty_zero", 64'(res), 64'd0);

        load_basic();
        run_row(3, 3, 5, 1'b1, res);
        check_eq("gaps_60", 64'(res), 64'd60);

        val_q = {};
        col_q = {};
        for (int k = 0; k < 16; k++) begin
            set_vec_elem(k, 32'h7FFF);
            val_q.push_back(32'h7FFF);
            col_q.push_back(int'($urandom_range(0, 15)));
        end
        run_row(16, 1, 0, 1'b0, res);
`ifdef SPMV_MAC_SAT_EN
        check_eq("overflow_sat", 64'(res), 64'h007FFFFFFF);
`else
        check_eq("overflow_wrap", 64'(res), 64'h03FFF00010);
`endif

        // Abort a 4-beat row after two beats.
        for (int k = 0; k < 16; k++) set_vec_elem(k, 1000 + k);
        bus_if.i_start     = 1'b1;
        bus_if.i_nnz       = 5'd4;
        bus_if.i_in_vector = vec_g;
        tick();
        bus_if.i_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus_if.i_val_valid = 1'b1;
            bus_if.i_mat_val   = 16'd300;
            bus_if.i_col_idx   = 4'(b);
            tick();
        end
        bus_if.i_val_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_all_zero("midrow_reset");
        rst = 1'b0;
        tick();
        load_basic();
        run_row(3, 0, 0, 1'b0, res);
        check_eq("after_reset_60", 64'(res), 64'd60);

        vec_g = '0;
        set_vec_elem(0, 1);
        val_q = {};
        col_q = {};
        for (int b = 0; b < 16; b++) begin
            val_q.push_back(1);
            col_q.push_back(0);
        end
        run_row(20, 0, 0, 1'b0, res);
        check_eq("clamp_16", 64'(res), 64'd16);

        for (int r = 0; r < 40; r++) begin
            int nnz = int'($urandom_range(0, 31));
            int eff = (nnz > 16) ? 16 : nnz;
            vec_g = {8{$urandom()}};
            val_q = {};
            col_q = {};
            for (int b = 0; b < eff; b++) begin
                val_q.push_back(int'($urandom_range(0, 65535)) - 32768);
                col_q.push_back(int'($urandom_range(0, 15)));
            end
            run_row(nnz, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spmv_row_mac.md
# spmv_row_mac

Row multiply-accumulate stage of the SpMV datapath. It sits directly downstream of the SRAM0 reader. At row start it snapshots the 256-bit input-vector buffer. It then consumes the 16-bit matrix-value stream, one non-zero per beat with its column index. Each value is multiplied by the selected input-vector element and summed into one row result, which is handed off under a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 16, width of matrix values and vector elements (signed two's complement)
- VEC_LEN, 16, elements in the input vector
- ACC_W, 40, accumulator and result width

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_start  input  1  begin a row; sampled only in IDLE
- i_nnz  input  5  non-zeros in the row (0..16); values 17..31 are treated as 16
- i_in_vector  input  256  16 × 16-bit elements; element k = bits [16k+15:16k]
- i_val_valid  input  1  matrix beat present
- i_mat_val  input  16  signed matrix value
- i_col_idx  input  4  column index selecting the input-vector element
- o_val_ready  output  1  stage accepts a beat
- o_result  output  ACC_W  row dot-product
- o_result_valid  output  1  o_result is valid
- i_result_ready  input  1  downstream accepts the result
- o_busy  output  1  state != IDLE
- o_state  output  2  IDLE=00, ACCUM=01, OUT=10

## Operation
- IDLE: o_val_ready=0. On i_start:
  - latch i_in_vector into vec_snap, the effective nnz into nnz_r, and clear acc and beat_cnt;
  - if nnz_r=0, go to OUT; otherwise go to ACCUM.
- ACCUM: o_val_ready=1. A beat is accepted when i_val_valid && o_val_ready.
  - On accept: acc <= acc + sext(i_mat_val × vec_snap[i_col_idx]), where the product is a signed 16×16→32 multiply sign-extended to ACC_W; beat_cnt increments.
  - When the accepted beat has beat_cnt = nnz_r−1, go to OUT.
  - No accept means acc and beat_cnt hold.
- OUT: o_result_valid=1, o_result = acc (after optional saturation). o_val_ready=0, so beats are not consumed.
  - When i_result_ready=1, go to IDLE and deassert o_result_valid on the next edge.
- Accumulation wraps modulo 2^ACC_W; no overflow flag is produced.
- i_start outside IDLE is ignored, including in the cycle the result is accepted. A new row requires a fresh i_start in IDLE.
- Changes on i_in_vector after the i_start cycle do not affect the current row.
- Reset asserted in any state, including mid-row, clears everything in the next edge:
  - state=IDLE, acc=0, beat_cnt=0, vec_snap=0;
  - outputs: o_val_ready=0, o_result=0, o_result_valid=0, o_busy=0, o_state=00.
  - A partial row is discarded and never reported.

## Timing
- i_start is sampled at edge 0. ACCUM is entered and o_val_ready=1 from edge 1.
- One beat per cycle, maximum throughput. A row of N non-zeros takes N accepting cycles.
- If the last beat is accepted at edge t, o_result_valid=1 from edge t+1 with the final sum.
- If nnz=0, o_result_valid=1 from edge 1 with o_result=0.
- o_result and o_result_valid remain stable while i_result_ready=0.
- Result accepted at edge u: IDLE at u+1. The earliest next i_start is sampled at u+1.
- There is no combinational path from i_val_valid or i_result_ready to any output.

## Configuration
- SPMV_MAC_SAT_EN:
  - Defined: o_result is the accumulator clamped to the signed 32-bit range [−2^31, 2^31−1], then sign-extended to ACC_W. Internal acc is still ACC_W wide and unclamped.
  - Undefined: o_result = acc, the raw ACC_W value.

## Test plan
- Basic dot-product:
  - Stimulus: element k = k+1, i_nnz=3, beats (2,col0), (−1,col5), (4,col15).
  - Required: o_result=60, with o_result_valid at the edge after the third beat.
- Empty row:
  - Stimulus: i_nnz=0.
  - Required: o_result_valid=1 at edge 1 with o_result=0. o_val_ready never asserts.
- Gaps and backpressure:
  - Stimulus: toggle i_val_valid with bubbles; hold i_result_ready=0 for 5 cycles; pulse i_start and change i_in_vector during OUT.
  - Required: sum unchanged by the bubbles; result stable while not ready; the i_start in OUT is ignored.
- Overflow:
  - Stimulus: all elements 0x7FFF, 16 beats of 0x7FFF.
  - Required without macro: o_result=40'h03FFF00010. Required with SPMV_MAC_SAT_EN: o_result=40'h007FFFFFFF.
- Reset mid-row:
  - Stimulus: assert i_rst after 2 of 4 beats, then run the basic dot-product test.
  - Required: all outputs are 0 after the reset edge; the following row returns 60 with no residue from the aborted row.
- Clamp:
  - Stimulus: i_nnz=20 with 16 beats of (1,col0), element0=1.
  - Required: the result appears after the 16th beat with o_result=16.
